// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational ALU: instruction FIFO, operand registers,
// single-issue sequencing with result writeback and a valid/ready result port.
module alu_issue_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             load_sel,
    input  logic [31:0]      load_data,
    output logic [31:0]      alu_inst,
    output logic [31:0]      alu_reg_a,
    output logic [31:0]      alu_reg_b,
    input  logic [31:0]      alu_res,
    input  logic [2:0]       alu_flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [31:0]      out_res,
    output logic [2:0]       out_flag,
    output logic [CNT_W-1:0] fifo_count,
    output logic             busy
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

    state_t           r_state;
    logic [31:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_reg_a;
    logic [31:0]      r_reg_b;
    logic [31:0]      r_alu_inst;
    logic [31:0]      r_out_inst;
    logic [31:0]      r_out_res;
    logic [2:0]       r_out_flag;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_load_ready;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_wr_en;
    logic [4:0]       w_dest;

    // in_ready depends on occupancy only, so a full FIFO refuses even a same-cycle pop
    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = in_valid && !w_full;
    // A pending operand load always wins over a pop
    assign w_pop   = !w_empty && !load_valid &&
                     ((r_state == S_IDLE) || (r_state == S_RESP && out_ready));

    always_comb begin
        w_wr_en = 1'b0;
        w_dest  = r_alu_inst[15:11];
        case (r_alu_inst[31:26])
            6'b000000: begin
                w_wr_en = 1'b1;
                w_dest  = r_alu_inst[15:11];
            end
            6'b001000, 6'b001001, 6'b001010, 6'b001011,
            6'b001100, 6'b001101, 6'b001110: begin
                w_wr_en = 1'b1;
                w_dest  = r_alu_inst[20:16];
            end
            default: w_wr_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= in_inst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_reg_a      <= '0;
            r_reg_b      <= '0;
            r_alu_inst   <= '0;
            r_out_inst   <= '0;
            r_out_res    <= '0;
            r_out_flag   <= '0;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_load_ready <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load_valid) begin
                        if (load_sel) r_reg_b <= load_data;
                        else          r_reg_a <= load_data;
                    end else if (w_pop) begin
                        r_alu_inst   <= r_mem[r_rd_ptr];
                        r_state      <= S_ISSUE;
                        r_busy       <= 1'b1;
                        r_load_ready <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    r_out_res   <= alu_res;
                    r_out_flag  <= alu_flag;
                    r_out_inst  <= r_alu_inst;
                    r_out_valid <= 1'b1;
                    r_state     <= S_RESP;
                    if (w_wr_en && w_dest == 5'd0) r_reg_a <= alu_res;
                    if (w_wr_en && w_dest == 5'd1) r_reg_b <= alu_res;
                end
                S_RESP: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_pop) begin
                            r_alu_inst <= r_mem[r_rd_ptr];
                            r_state    <= S_ISSUE;
                        end else begin
                            r_state      <= S_IDLE;
                            r_busy       <= 1'b0;
                            r_load_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_busy       <= 1'b0;
                    r_load_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = !w_full;
    assign load_ready = r_load_ready;
    assign alu_inst   = r_alu_inst;
    assign alu_reg_a  = r_reg_a;
    assign alu_reg_b  = r_reg_b;
    assign out_valid  = r_out_valid;
    assign out_inst   = r_out_inst;
    assign out_res    = r_out_res;
    assign out_flag   = r_out_flag;
    assign fifo_count = r_count;
    assign busy       = r_busy;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed steps plus a random phase, scored against an
// in-order instruction queue and architectural register model.
module tb_alu_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, load_valid, load_ready, load_sel;
    logic [31:0] in_inst, load_data, alu_inst, alu_reg_a, alu_reg_b, alu_res;
    logic [31:0] out_inst, out_res;
    logic [2:0]  alu_flag, out_flag;
    logic        out_valid, out_ready, busy;
    logic [2:0]  fifo_count;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] ra, rb;
    logic [31:0] q[$];
    logic        last_load;
    logic [31:0] save_a;

    alu_issue_ctrl #(.FIFO_DEPTH(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .load_valid(load_valid), .load_ready(load_ready), .load_sel(load_sel), .load_data(load_data),
        .alu_inst(alu_inst), .alu_reg_a(alu_reg_a), .alu_reg_b(alu_reg_b),
        .alu_res(alu_res), .alu_flag(alu_flag),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_res(out_res), .out_flag(out_flag),
        .fifo_count(fifo_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: operand index 0 selects reg_a, 1 selects reg_b
    function automatic logic [31:0] alu_fn(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] rs_v, rt_v, imm;
        rs_v = i[21] ? b : a;
        rt_v = i[16] ? b : a;
        imm  = {{16{i[15]}}, i[15:0]};
        if (i[31:26] == 6'd0)         return rs_v + rt_v;
        else if (i[31:29] == 3'b001)  return rs_v + imm;
        else                          return imm;
    endfunction

    function automatic logic [2:0] flag_fn(input logic [31:0] r);
        return {r == 32'd0, r[31], ^r};
    endfunction

    function automatic int dest_of(input logic [31:0] i);
        int op;
        op = int'(i[31:26]);
        if (op == 0) return int'(i[15:11]);
        if (op >= 8 && op <= 14) return int'(i[20:16]);
        return -1;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [5:0] op;
        case ($urandom_range(0, 5))
            0, 1:    op = 6'd0;
            2, 3:    op = 6'd8 + 6'($urandom_range(0, 7));
            4:       case ($urandom_range(0, 3))
                         0: op = 6'h04; 1: op = 6'h05; 2: op = 6'h23; default: op = 6'h2b;
                     endcase
            default: op = 6'($urandom);
        endcase
        return {op, 5'($urandom_range(0, 1)), 5'($urandom_range(0, 2)),
                5'($urandom_range(0, 2)), 11'($urandom)};
    endfunction

    assign alu_res  = alu_fn(alu_inst, alu_reg_a, alu_reg_b);
    assign alu_flag = flag_fn(alu_res);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: score handshakes visible now, advance to the next falling edge
    task automatic cyc();
        logic        p, l, t, lsel;
        logic [31:0] pi, ldat, ei, er;
        int          d;
        p = in_valid && in_ready;
        l = load_valid && load_ready;
        t = out_valid && out_ready;
        pi = in_inst; lsel = load_sel; ldat = load_data;
        last_load = l;
        if (t) begin
            checks++;
            assert (q.size() != 0) else begin
                failures++;
                $error("FAIL spurious_result observed=%h expected=none", out_inst);
            end
            if (q.size() != 0) begin
                ei = q.pop_front();
                er = alu_fn(ei, ra, rb);
                chk("out_inst", out_inst, ei);
                chk("out_res", out_res, er);
                chk("out_flag", 32'(out_flag), 32'(flag_fn(er)));
                d = dest_of(ei);
                if (d == 0) ra = er;
                if (d == 1) rb = er;
                chk("wb_reg_a", alu_reg_a, ra);
                chk("wb_reg_b", alu_reg_b, rb);
            end
        end
        @(posedge clk);
        if (p) q.push_back(pi);
        if (l) begin
            if (lsel) rb = ldat;
            else      ra = ldat;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        in_valid = 0; load_valid = 0; out_ready = 0; rst = 1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst = 0;
        q.delete(); ra = '0; rb = '0;
    endtask

    task automatic do_load(input logic sel, input logic [31:0] data);
        load_valid = 1; load_sel = sel; load_data = data;
        cyc();
        load_valid = 0;
    endtask

    task automatic push_issue(input logic [31:0] inst);
        in_valid = 1; in_inst = inst;
        cyc();
        in_valid = 0;
        cyc(); cyc();
        chk("issue_out_valid", 32'(out_valid), 32'd1);
        chk("issue_out_inst", out_inst, inst);
    endtask

    task automatic consume();
        out_ready = 1;
        cyc();
        out_ready = 0;
    endtask

    initial begin
        in_inst = '0; load_sel = 0; load_data = '0; last_load = 0;
        do_reset(2);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_load_ready", 32'(load_ready), 32'd1);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alu_inst", alu_inst, 32'd0);
        chk("rst_reg_a", alu_reg_a, 32'd0);
        chk("rst_reg_b", alu_reg_b, 32'd0);
        chk("rst_out_res", out_res, 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_flag", 32'(out_flag), 32'd0);

        // Preload then add with exact latency
        do_load(0, 32'd5);
        do_load(1, 32'd7);
        chk("pre_reg_a", alu_reg_a, 32'd5);
        chk("pre_reg_b", alu_reg_b, 32'd7);
        in_valid = 1; in_inst = 32'h00010820;
        cyc();
        in_valid = 0;
        chk("e0_count", 32'(fifo_count), 32'd1);
        chk("e0_out_valid", 32'(out_valid), 32'd0);
        cyc();
        chk("e1_busy", 32'(busy), 32'd1);
        chk("e1_alu_inst", alu_inst, 32'h00010820);
        chk("e1_out_valid", 32'(out_valid), 32'd0);
        cyc();
        chk("e2_out_valid", 32'(out_valid), 32'd1);
        chk("add_res", out_res, 32'd12);
        chk("add_reg_b", alu_reg_b, 32'd12);
        chk("add_reg_a", alu_reg_a, 32'd5);
        consume();
        chk("post_out_valid", 32'(out_valid), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);

        push_issue(32'h2000FFFF);
        chk("addi_res", out_res, 32'd4);
        chk("addi_reg_a", alu_reg_a, 32'd4);
        consume();
        push_issue(32'h10000003);
        chk("beq_res", out_res, 32'd3);
        chk("beq_reg_a", alu_reg_a, 32'd4);
        chk("beq_reg_b", alu_reg_b, 32'd12);
        consume();

        // Back-pressure fill: 5 of 6 accepted
        for (int k = 0; k < 6; k++) begin
            in_valid = 1; in_inst = {6'd0, 5'd0, 5'd1, 5'd7, 11'(k)};
            chk("fill_in_ready", 32'(in_ready), (k < 5) ? 32'd1 : 32'd0);
            cyc();
        end
        in_valid = 0;
        chk("fill_count", 32'(fifo_count), 32'd4);
        chk("fill_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1;
        for (int k = 0; k < 10; k++) begin
            chk("drain_rhythm", 32'(out_valid), (k % 2 == 0) ? 32'd1 : 32'd0);
            cyc();
        end
        out_ready = 0;
        chk("drain_q", 32'(q.size()), 32'd0);
        chk("drain_busy", 32'(busy), 32'd0);

        // Load held while busy, taken in first IDLE cycle, pop delayed
        save_a = alu_reg_a;
        in_valid = 1; in_inst = 32'h10000005;
        cyc();
        in_inst = 32'h00000820;
        cyc();
        in_valid = 0;
        load_valid = 1; load_sel = 0; load_data = 32'h0000AAAA;
        chk("ld_issue_ready", 32'(load_ready), 32'd0);
        chk("ld_issue_busy", 32'(busy), 32'd1);
        cyc();
        chk("ld_resp_ready", 32'(load_ready), 32'd0);
        chk("ld_resp_valid", 32'(out_valid), 32'd1);
        chk("ld_resp_reg_a", alu_reg_a, save_a);
        cyc();
        chk("ld_hold_reg_a", alu_reg_a, save_a);
        out_ready = 1;
        cyc();
        out_ready = 0;
        chk("ld_idle_busy", 32'(busy), 32'd0);
        chk("ld_idle_ready", 32'(load_ready), 32'd1);
        chk("ld_idle_count", 32'(fifo_count), 32'd1);
        cyc();
        load_valid = 0;
        chk("ld_taken_reg_a", alu_reg_a, 32'h0000AAAA);
        chk("ld_nopop_count", 32'(fifo_count), 32'd1);
        chk("ld_nopop_busy", 32'(busy), 32'd0);
        cyc();
        chk("ld_pop_busy", 32'(busy), 32'd1);
        chk("ld_pop_inst", alu_inst, 32'h00000820);
        cyc();
        chk("ld_y_valid", 32'(out_valid), 32'd1);
        consume();

        // rd=5 writes neither register
        do_load(0, 32'h11);
        do_load(1, 32'h22);
        push_issue(32'h00012820);
        chk("rd5_res", out_res, 32'h33);
        chk("rd5_reg_a", alu_reg_a, 32'h11);
        chk("rd5_reg_b", alu_reg_b, 32'h22);
        consume();

        // Reset while in RESP with 3 queued entries
        for (int k = 0; k < 4; k++) begin
            in_valid = 1; in_inst = 32'h00000820 + 32'(k);
            cyc();
        end
        in_valid = 0;
        chk("prerst_count", 32'(fifo_count), 32'd3);
        chk("prerst_valid", 32'(out_valid), 32'd1);
        do_reset(1);
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_count", 32'(fifo_count), 32'd0);
        chk("mrst_reg_a", alu_reg_a, 32'd0);
        chk("mrst_reg_b", alu_reg_b, 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1;
        for (int k = 0; k < 6; k++) begin
            chk("mrst_quiet", 32'(out_valid), 32'd0);
            cyc();
        end
        out_ready = 0;

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            in_valid = ($urandom_range(0, 9) < 6);
            in_inst = rand_inst();
            out_ready = $urandom_range(0, 1);
            if (!load_valid && $urandom_range(0, 7) == 0) begin
                load_valid = 1; load_sel = $urandom_range(0, 1); load_data = 32'($urandom_range(0, 255));
            end
            cyc();
            if (last_load) load_valid = 0;
        end
        in_valid = 0; load_valid = 0; out_ready = 1;
        for (int k = 0; k < 60 && (q.size() != 0 || busy); k++) cyc();
        chk("final_q_empty", 32'(q.size()), 32'd0);
        chk("final_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
